// File: rtl/ram_fill_ctrl.sv
// ram_fill_ctrl: access sequencer in front of a single-port RAM.
// Fills the whole RAM with (addr*PAT_STEP) mod 2**DW on init_start, otherwise
// forwards single-beat host reads/writes and returns read data with a strobe.
//
// Host handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready never depends on req_valid; it is low while
// a fill or a read is in flight and in the cycle init_start is asserted.
// The host must hold req_* stable until the transfer. rsp_valid is a one-cycle
// strobe with no backpressure; rsp_rdata holds until the next read response.
module ram_fill_ctrl #(
    parameter int AW       = 10,
    parameter int DW       = 8,
    parameter int PAT_STEP = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_start,
    output logic          init_busy,
    output logic          init_done,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_write,
    output logic          ram_select,
    input  logic [DW-1:0] ram_dout,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          ram_write_q, ram_write_d;
    logic          ram_select_q, ram_select_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          init_busy_q, init_busy_d;
    logic          init_done_q, init_done_d;

    // cnt_q is the address being written in the current FILL cycle.
    logic [AW-1:0] fill_next;
    logic [DW-1:0] fill_pat;

    assign fill_next = cnt_q + AW'(1);
    assign fill_pat  = DW'(fill_next * PAT_STEP);

    assign req_ready  = (state_q == IDLE) && !init_start;
    assign init_busy  = init_busy_q;
    assign init_done  = init_done_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign ram_write  = ram_write_q;
    assign ram_select = ram_select_q;
    assign dbg_state  = state_q;

    // Next-state and next-output logic; pulses and RAM strobes default low.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_write_d  = 1'b0;
        ram_select_d = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        init_done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (init_start) begin
                    // First fill write (address 0) goes out with the state change.
                    state_d      = FILL;
                    cnt_d        = '0;
                    ram_addr_d   = '0;
                    ram_din_d    = '0;
                    ram_select_d = 1'b1;
                    ram_write_d  = 1'b1;
                end else if (req_valid) begin
                    ram_addr_d   = req_addr;
                    ram_select_d = 1'b1;
                    if (req_write) begin
                        ram_write_d = 1'b1;
                        ram_din_d   = req_wdata;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            FILL: begin
                if (cnt_q == {AW{1'b1}}) begin
                    // Last address was written this cycle; counter wraps to 0.
                    state_d     = IDLE;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d        = fill_next;
                    ram_addr_d   = fill_next;
                    ram_din_d    = fill_pat;
                    ram_select_d = 1'b1;
                    ram_write_d  = 1'b1;
                end
            end
            RD: begin
                // RAM is driven for a read this cycle; capture its output.
                rsp_rdata_d = ram_dout;
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        init_busy_d = (state_d == FILL);
    end

    // State, counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_write_q  <= 1'b0;
            ram_select_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            init_busy_q  <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_write_q  <= ram_write_d;
            ram_select_q <= ram_select_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            init_busy_q  <= init_busy_d;
            init_done_q  <= init_done_d;
        end
    end

endmodule

// File: doc/ram_fill_ctrl.md
Name: ram_fill_ctrl

Overview:
- Access sequencer directly upstream of the 1024x8 single-port RAM; it drives the RAM's address, data_in, write and select.
- On command, fills every location with the deterministic pattern data = (2*addr) mod 256.
- Otherwise arbitrates single-beat host read/write requests onto the RAM port using a valid/ready handshake, and returns read data with a one-cycle response strobe.

Parameters:
- AW, 10, address width; RAM depth = 2**AW
- DW, 8, data width
- PAT_STEP, 2, fill pattern multiplier: pattern = (addr*PAT_STEP) mod 2**DW

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- init_start  in  1  single-cycle pulse: begin a fill
- init_busy  out  1  high while a fill is in progress
- init_done  out  1  one-cycle pulse after the last fill write
- req_valid  in  1  host request valid
- req_ready  out  1  host request accepted when valid&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  AW  request address
- req_wdata  in  DW  write data
- rsp_valid  out  1  one-cycle read-data strobe; no backpressure
- rsp_rdata  out  DW  read data, held until the next read response
- ram_addr  out  AW  to RAM address
- ram_din  out  DW  to RAM data_in
- ram_write  out  1  to RAM write
- ram_select  out  1  to RAM select
- ram_dout  in  DW  from RAM data_out; combinational read when select=1, write=0

Behaviour:
- All ram_* outputs, rsp_*, init_busy and init_done are registered.
- Reset (async, rst_n=0): state=IDLE; every output listed above = 0; fill counter = 0.
- RAM port timing: write occurs in any cycle with ram_select=1 and ram_write=1. Reads sample ram_dout at the end of a cycle with ram_select=1 and ram_write=0.
- req_ready is combinational: (state==IDLE) && !init_start.
- FSM states: IDLE, FILL, RD.
- IDLE, init_start=1:
  - Go to FILL; counter=0; init_busy=1 from the next cycle.
  - init_start takes priority over a simultaneous req_valid; that request is not accepted.
- IDLE, write accepted at edge T:
  - Cycle T+1: ram_select=1, ram_write=1, ram_addr=req_addr, ram_din=req_wdata.
  - Stay IDLE. Back-to-back writes are sustained at 1 per cycle.
- IDLE, read accepted at edge T:
  - Cycle T+1: state=RD, ram_select=1, ram_write=0, ram_addr=req_addr, req_ready=0.
  - End of T+1: rsp_rdata<=ram_dout.
  - Cycle T+2: rsp_valid=1 for exactly one cycle; state=IDLE, so req_ready may be 1 again.
  - Read throughput is 1 per 2 cycles.
- IDLE, no request: ram_select=0, ram_write=0; ram_addr and ram_din hold their last values.
- FILL:
  - Each cycle: ram_select=1, ram_write=1, ram_addr=counter, ram_din=(counter*PAT_STEP) mod 2**DW; counter increments.
  - Exactly 2**AW write cycles, addresses 0..1023 ascending.
  - After the cycle with ram_addr=1023: next cycle state=IDLE, init_busy=0, init_done=1 (one cycle), ram_select=0. The counter wraps to 0.
  - init_start during FILL is ignored; the fill does not restart.
  - req_ready=0 throughout FILL; requests stall without loss of host state.
- Pattern arithmetic: the product is truncated to DW bits. Example: addr 200 -> 400 mod 256 = 144.
- Write-then-read to the same address on consecutive accepts returns the new data.
- Reset mid-fill:
  - Immediate abort; no init_done pulse.
  - RAM contents are left partially filled and are not defined by this block.
  - A new init_start is required after reset.
- Reset mid-read: the pending rsp_valid is dropped.

Test Plan:
- Reset, then one init_start pulse -> init_busy high for 1024 cycles; ram writes cover addr 0..1023 with din 0,2,...,254,0,...; single init_done pulse; then req_ready=1.
- After fill, read addr 5, 128, 200, 1023 -> rsp_rdata 10, 0, 144, 254; each rsp_valid 2 cycles after accept; req_ready low in the RD cycle.
- Write 0xA5 to addr 77, then read addr 77 on the next accept -> rsp_rdata=0xA5.
- Four back-to-back writes (addr 1..4) -> four consecutive ram_write cycles, req_ready never drops.
- init_start and req_valid (read addr 3) in the same cycle -> request not accepted, fill starts. Request held -> accepted the cycle after init_done, rsp_rdata=6. Second init_start mid-fill -> exactly 1024 writes.
- Assert rst_n=0 at fill count 500 -> all outputs 0 immediately, no init_done. Restart fill -> full 1024-write sequence from addr 0.
